pulse_scheduler: RTL and testbench
==================================

PULSE_SCHEDULER -- requirements
Module: pulse_scheduler

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset; ports listed in REQ-002..REQ-008, clock and reset first.
REQ-002 clk  in  1  system clock; rst  in  1  synchronous active-high reset; clk_en  in  1  tick enable for all counting and state advance.
REQ-003 SYS_TIME  in  64  current system time in ticks; SPI_WR  in  1  one-cycle pulse, new parameter set valid.
REQ-004 FREQ  in  48 and FREQ_STEP  in  48: start frequency word and per-pulse hop step; FREQ_RATE  in  32: intra-pulse LFM rate.
REQ-005 TIME_START  in  64  sequence start time; N_impulse  in  16  pulse count; TYPE_impulse  in  8  mode bits (bit0 hop, bit1 LFM, others ignored).
REQ-006 Interval_Ti, Interval_Tp, Tblank1, Tblank2  in  32 each: pulse width, period, head blank, tail blank, in ticks.
REQ-007 DDS_FREQ  out  48, DDS_RATE  out  32, DDS_LOAD  out  1 (one-cycle load strobe), TX_GATE  out  1, BLANK  out  1.
REQ-008 PULSE_CNT  out  16 (index of current pulse), BUSY  out  1, DONE  out  1 (one-cycle), ERR  out  1 (one-cycle), LATE  out  1 (sticky until next SPI_WR).

Function
REQ-009 SHALL implement states IDLE, ARMED, RUN; BUSY = (state != IDLE).
REQ-010 On SPI_WR in any state SHALL latch all parameter inputs into a shadow set, abort any running sequence and clear LATE on the next cycle; TX_GATE and BLANK SHALL be low the cycle after SPI_WR.
REQ-011 Latched set SHALL be invalid if N=0, Ti=0, Tp=0 or Ti>=Tp; invalid -> ERR pulse one cycle after SPI_WR, state IDLE.
REQ-012 A valid set SHALL move to ARMED one cycle after SPI_WR.
REQ-013 In ARMED, on a clk_en cycle k with SYS_TIME >= TIME_START (unsigned), state SHALL be RUN at k+1; if SYS_TIME > TIME_START at the first ARMED compare, LATE SHALL set.
REQ-014 RUN SHALL keep a 32-bit period counter t (0..Tp-1) incremented on clk_en; t=0 at k+1.
REQ-015 DDS_LOAD SHALL pulse for one cycle at each t=0 entry; DDS_FREQ SHALL equal FREQ for pulse 0 and, if TYPE bit0, previous DDS_FREQ+FREQ_STEP mod 2^48 per later pulse, else FREQ.
REQ-016 DDS_RATE SHALL equal FREQ_RATE when TYPE bit1 set, else 0, updated together with DDS_LOAD.
REQ-017 TX_GATE SHALL be high exactly when RUN and t < Ti (Ti cycles of clk_en per pulse).
REQ-018 BLANK SHALL be high when RUN and (t < Tblank1 or t + Tblank2 >= Tp, computed 33-bit); Tblank2 >= Tp blanks whole period.
REQ-019 At t=Tp-1 with clk_en: if PULSE_CNT=N-1, DONE pulses next cycle and state goes IDLE; else t wraps to 0 and PULSE_CNT increments.
REQ-020 With clk_en low, state, counters and outputs SHALL hold (DDS_LOAD, DONE, ERR excepted: they deassert).
REQ-021 SYS_TIME jumps SHALL affect only the ARMED compare; RUN timing is counter-based only.
REQ-022 SPI_WR coincident with DONE-cycle terminal count SHALL win: no DONE, new set processed per REQ-010.

Reset
REQ-023 rst SHALL force IDLE, t=0, PULSE_CNT=0, DDS_FREQ=0, DDS_RATE=0, shadow set=0, all 1-bit outputs 0; rst overrides SPI_WR and clk_en.
REQ-024 rst mid-RUN SHALL drop TX_GATE and BLANK in the cycle after rst is sampled.

Structure
REQ-025 Package pulse_sched_pkg SHALL hold the state enum, the parameter struct (shadow set) and TYPE bit-position constants.
REQ-026 One sub-module pulse_timer SHALL contain the period counter and the TX_GATE/BLANK compares; the FSM and frequency accumulator stay in pulse_scheduler.

Verification
REQ-027 Ti=4, Tp=10, N=3, TIME_START=100, SYS_TIME counting from 50, clk_en=1 -> TX_GATE 4 high/6 low x3, DONE once, three DDS_LOAD pulses 10 cycles apart.
REQ-028 TYPE=0x01, FREQ=0xFFFF_FFFF_FFFE, STEP=3, N=3 -> DDS_FREQ 0xFFFF_FFFF_FFFE, 0x1, 0x4.
REQ-029 Ti=10, Tp=10 -> ERR pulse, BUSY stays 0; N=0 -> same.
REQ-030 TIME_START=20 while SYS_TIME=500 -> RUN next cycle, LATE=1; Tblank1=2, Tblank2=3, Tp=10 -> BLANK at t=0,1,7,8,9.
REQ-031 SPI_WR at pulse 2 of N=5 -> TX_GATE low next cycle, re-ARM with new set, no DONE from old set.
REQ-032 clk_en toggling 1/0 -> all durations doubled in clk cycles; rst at t=3 -> all outputs 0, IDLE.

Source files
------------

// File: rtl/pulse_sched_pkg.sv
// Shared types for the pulse scheduler: FSM state, latched parameter set and TYPE bit positions.
package pulse_sched_pkg;

  localparam int unsigned TIME_W = 64;
  localparam int unsigned FREQ_W = 48;
  localparam int unsigned RATE_W = 32;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned TYPE_W = 8;
  localparam int unsigned INTV_W = 32;

  localparam int unsigned TYPE_HOP_BIT = 0;
  localparam int unsigned TYPE_LFM_BIT = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_RUN   = 2'd2
  } state_e;

  typedef struct packed {
    logic [FREQ_W-1:0] freq;
    logic [FREQ_W-1:0] freq_step;
    logic [RATE_W-1:0] freq_rate;
    logic [TIME_W-1:0] time_start;
    logic [CNT_W-1:0]  n_impulse;
    logic [TYPE_W-1:0] type_impulse;
    logic [INTV_W-1:0] ti;
    logic [INTV_W-1:0] tp;
    logic [INTV_W-1:0] tblank1;
    logic [INTV_W-1:0] tblank2;
  } sched_cfg_t;

  // A set is usable only with at least one pulse and 0 < Ti < Tp.
  function automatic logic cfg_valid(input sched_cfg_t c);
    return (c.n_impulse != '0) && (c.ti != '0) && (c.tp != '0) && (c.ti < c.tp);
  endfunction

endpackage

// File: rtl/pulse_timer.sv
// Period counter and gate/blank window compares for one pulse period.
// Ports: clk, rst; run_d_i (scheduler will be in RUN next cycle), restart_i (start at t=0),
// tick_i (clk_en while running); ti/tp/tblank1/tblank2 window parameters;
// period_end_c_o (t == Tp-1, combinational), tx_gate_o, blank_o (registered).
module pulse_timer
  import pulse_sched_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              run_d_i,
  input  logic              restart_i,
  input  logic              tick_i,
  input  logic [INTV_W-1:0] ti_i,
  input  logic [INTV_W-1:0] tp_i,
  input  logic [INTV_W-1:0] tblank1_i,
  input  logic [INTV_W-1:0] tblank2_i,
  output logic              period_end_c_o,
  output logic              tx_gate_o,
  output logic              blank_o
);

  logic [INTV_W-1:0] t_q, t_d;
  logic              tx_q, tx_d;
  logic              blank_q, blank_d;
  logic [INTV_W:0]   tail_sum_c;

  assign period_end_c_o = (t_q == (tp_i - INTV_W'(1)));

  // Outputs are computed from the next counter value so they line up with the state they describe.
  always_comb begin
    t_d = t_q;
    if (!run_d_i || restart_i) begin
      t_d = '0;
    end else if (tick_i) begin
      t_d = period_end_c_o ? '0 : t_q + INTV_W'(1);
    end
    tail_sum_c = {1'b0, t_d} + {1'b0, tblank2_i};
    tx_d       = run_d_i && (t_d < ti_i);
    blank_d    = run_d_i && ((t_d < tblank1_i) || (tail_sum_c >= {1'b0, tp_i}));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      t_q     <= '0;
      tx_q    <= 1'b0;
      blank_q <= 1'b0;
    end else begin
      t_q     <= t_d;
      tx_q    <= tx_d;
      blank_q <= blank_d;
    end
  end

  assign tx_gate_o = tx_q;
  assign blank_o   = blank_q;

endmodule

// File: rtl/pulse_scheduler.sv
// Pulse train scheduler: latches a parameter set on SPI_WR, waits for TIME_START, then emits
// N pulses of width Ti every Tp ticks with DDS frequency/rate loads and blanking.
// Ports: clk, rst, clk_en, SYS_TIME, SPI_WR, parameter inputs (FREQ..Tblank2);
// outputs DDS_FREQ/DDS_RATE/DDS_LOAD, TX_GATE, BLANK, PULSE_CNT, BUSY, DONE, ERR, LATE.
module pulse_scheduler
  import pulse_sched_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clk_en,
  input  logic [TIME_W-1:0] SYS_TIME,
  input  logic              SPI_WR,
  input  logic [FREQ_W-1:0] FREQ,
  input  logic [FREQ_W-1:0] FREQ_STEP,
  input  logic [RATE_W-1:0] FREQ_RATE,
  input  logic [TIME_W-1:0] TIME_START,
  input  logic [CNT_W-1:0]  N_impulse,
  input  logic [TYPE_W-1:0] TYPE_impulse,
  input  logic [INTV_W-1:0] Interval_Ti,
  input  logic [INTV_W-1:0] Interval_Tp,
  input  logic [INTV_W-1:0] Tblank1,
  input  logic [INTV_W-1:0] Tblank2,
  output logic [FREQ_W-1:0] DDS_FREQ,
  output logic [RATE_W-1:0] DDS_RATE,
  output logic              DDS_LOAD,
  output logic              TX_GATE,
  output logic              BLANK,
  output logic [CNT_W-1:0]  PULSE_CNT,
  output logic              BUSY,
  output logic              DONE,
  output logic              ERR,
  output logic              LATE
);

  state_e            state_q, state_d;
  sched_cfg_t        cfg_q, cfg_d, cfg_in_c;
  logic [CNT_W-1:0]  pulse_cnt_q, pulse_cnt_d;
  logic [FREQ_W-1:0] dds_freq_q, dds_freq_d;
  logic [RATE_W-1:0] dds_rate_q, dds_rate_d;
  logic              dds_load_q, dds_load_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              late_q, late_d;
  logic              first_cmp_q, first_cmp_d;
  logic              run_start_c;
  logic              run_d_c;
  logic              period_end_c;
  logic [RATE_W-1:0] rate_sel_c;
  logic              unused_type_bits;

  always_comb begin
    cfg_in_c.freq         = FREQ;
    cfg_in_c.freq_step    = FREQ_STEP;
    cfg_in_c.freq_rate    = FREQ_RATE;
    cfg_in_c.time_start   = TIME_START;
    cfg_in_c.n_impulse    = N_impulse;
    cfg_in_c.type_impulse = TYPE_impulse;
    cfg_in_c.ti           = Interval_Ti;
    cfg_in_c.tp           = Interval_Tp;
    cfg_in_c.tblank1      = Tblank1;
    cfg_in_c.tblank2      = Tblank2;
  end

  // Only the hop and LFM mode bits carry meaning.
  assign unused_type_bits = ^cfg_q.type_impulse[TYPE_W-1:2];

  assign rate_sel_c = cfg_q.type_impulse[TYPE_LFM_BIT] ? cfg_q.freq_rate : '0;

  // Next-state / output logic; SPI_WR has priority over everything except reset.
  always_comb begin
    state_d     = state_q;
    cfg_d       = cfg_q;
    pulse_cnt_d = pulse_cnt_q;
    dds_freq_d  = dds_freq_q;
    dds_rate_d  = dds_rate_q;
    dds_load_d  = 1'b0;
    done_d      = 1'b0;
    err_d       = 1'b0;
    late_d      = late_q;
    first_cmp_d = first_cmp_q;
    run_start_c = 1'b0;

    if (SPI_WR) begin
      cfg_d       = cfg_in_c;
      pulse_cnt_d = '0;
      late_d      = 1'b0;
      first_cmp_d = 1'b1;
      if (cfg_valid(cfg_in_c)) begin
        state_d = ST_ARMED;
      end else begin
        state_d = ST_IDLE;
        err_d   = 1'b1;
      end
    end else if (clk_en) begin
      case (state_q)
        ST_ARMED: begin
          first_cmp_d = 1'b0;
          if (SYS_TIME >= cfg_q.time_start) begin
            state_d     = ST_RUN;
            run_start_c = 1'b1;
            pulse_cnt_d = '0;
            dds_load_d  = 1'b1;
            dds_freq_d  = cfg_q.freq;
            dds_rate_d  = rate_sel_c;
            if (first_cmp_q && (SYS_TIME > cfg_q.time_start)) begin
              late_d = 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (period_end_c) begin
            if (pulse_cnt_q == (cfg_q.n_impulse - CNT_W'(1))) begin
              state_d = ST_IDLE;
              done_d  = 1'b1;
            end else begin
              pulse_cnt_d = pulse_cnt_q + CNT_W'(1);
              dds_load_d  = 1'b1;
              dds_freq_d  = cfg_q.type_impulse[TYPE_HOP_BIT] ? (dds_freq_q + cfg_q.freq_step)
                                                             : cfg_q.freq;
              dds_rate_d  = rate_sel_c;
            end
          end
        end
        default: begin
        end
      endcase
    end

    run_d_c = (state_d == ST_RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cfg_q       <= '0;
      pulse_cnt_q <= '0;
      dds_freq_q  <= '0;
      dds_rate_q  <= '0;
      dds_load_q  <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      late_q      <= 1'b0;
      first_cmp_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cfg_q       <= cfg_d;
      pulse_cnt_q <= pulse_cnt_d;
      dds_freq_q  <= dds_freq_d;
      dds_rate_q  <= dds_rate_d;
      dds_load_q  <= dds_load_d;
      done_q      <= done_d;
      err_q       <= err_d;
      late_q      <= late_d;
      first_cmp_q <= first_cmp_d;
    end
  end

  pulse_timer u_timer (
    .clk            (clk),
    .rst            (rst),
    .run_d_i        (run_d_c),
    .restart_i      (run_start_c),
    .tick_i         (clk_en && (state_q == ST_RUN)),
    .ti_i           (cfg_q.ti),
    .tp_i           (cfg_q.tp),
    .tblank1_i      (cfg_q.tblank1),
    .tblank2_i      (cfg_q.tblank2),
    .period_end_c_o (period_end_c),
    .tx_gate_o      (TX_GATE),
    .blank_o        (BLANK)
  );

  assign DDS_FREQ  = dds_freq_q;
  assign DDS_RATE  = dds_rate_q;
  assign DDS_LOAD  = dds_load_q;
  assign PULSE_CNT = pulse_cnt_q;
  assign BUSY      = (state_q != ST_IDLE);
  assign DONE      = done_q;
  assign ERR       = err_q;
  assign LATE      = late_q;

endmodule

// File: tb/tb_pulse_scheduler.sv
// Self-checking bench for pulse_scheduler: per-cycle comparison against a tick-count based
// reference model, a validity table, directed multi-cycle sequences and randomized traffic.
module tb_pulse_scheduler;

  typedef struct packed {
    logic [47:0] freq;
    logic [47:0] step;
    logic [31:0] rate;
    logic [63:0] ts;
    logic [15:0] n;
    logic [7:0]  typ;
    logic [31:0] ti;
    logic [31:0] tp;
    logic [31:0] tb1;
    logic [31:0] tb2;
  } cfg_t;

  typedef struct packed {
    logic [15:0] n;
    logic [31:0] ti;
    logic [31:0] tp;
    logic        exp_err;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst, clk_en, SPI_WR;
  logic [63:0] SYS_TIME;
  logic [47:0] FREQ, FREQ_STEP;
  logic [31:0] FREQ_RATE;
  logic [63:0] TIME_START;
  logic [15:0] N_impulse;
  logic [7:0]  TYPE_impulse;
  logic [31:0] Interval_Ti, Interval_Tp, Tblank1, Tblank2;
  logic [47:0] DDS_FREQ;
  logic [31:0] DDS_RATE;
  logic        DDS_LOAD, TX_GATE, BLANK, BUSY, DONE, ERR, LATE;
  logic [15:0] PULSE_CNT;

  always #5 clk = ~clk;

  pulse_scheduler dut (
    .clk(clk), .rst(rst), .clk_en(clk_en), .SYS_TIME(SYS_TIME), .SPI_WR(SPI_WR),
    .FREQ(FREQ), .FREQ_STEP(FREQ_STEP), .FREQ_RATE(FREQ_RATE), .TIME_START(TIME_START),
    .N_impulse(N_impulse), .TYPE_impulse(TYPE_impulse), .Interval_Ti(Interval_Ti),
    .Interval_Tp(Interval_Tp), .Tblank1(Tblank1), .Tblank2(Tblank2),
    .DDS_FREQ(DDS_FREQ), .DDS_RATE(DDS_RATE), .DDS_LOAD(DDS_LOAD), .TX_GATE(TX_GATE),
    .BLANK(BLANK), .PULSE_CNT(PULSE_CNT), .BUSY(BUSY), .DONE(DONE), .ERR(ERR), .LATE(LATE)
  );

  int n_checks = 0;
  int n_fail   = 0;

  cfg_t        cur;
  logic [63:0] st;
  bit          st_freeze;

  // Reference model: phase 0 idle, 1 armed, 2 running; m_k counts clk_en ticks since run start.
  int              m_phase;
  longint unsigned m_k;
  bit              m_first;
  cfg_t            m_cfg;
  logic [47:0]     e_freq;
  logic [31:0]     e_rate;
  logic [15:0]     e_cnt;
  logic            e_load, e_done, e_err, e_late, e_tx, e_blank;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic bit cfg_ok(input cfg_t c);
    return (c.n != 0) && (c.ti != 0) && (c.tp != 0) && (c.ti < c.tp);
  endfunction

  task automatic do_load(input longint unsigned p);
    e_load = 1'b1;
    e_cnt  = 16'(p);
    e_freq = m_cfg.typ[0] ? 48'(m_cfg.freq + 64'(p) * m_cfg.step) : m_cfg.freq;
    e_rate = m_cfg.typ[1] ? m_cfg.rate : 32'd0;
  endtask

  task automatic model_edge(input bit wr, input bit en, input bit r);
    longint unsigned t, tp;
    e_load = 1'b0; e_done = 1'b0; e_err = 1'b0;
    if (r) begin
      m_phase = 0; m_k = 0; m_first = 1'b0; m_cfg = '0;
      e_freq = '0; e_rate = '0; e_cnt = '0; e_late = 1'b0;
    end else if (wr) begin
      m_cfg = cur; e_late = 1'b0; e_cnt = '0; m_first = 1'b1;
      if (cfg_ok(cur)) m_phase = 1;
      else begin m_phase = 0; e_err = 1'b1; end
    end else if (en) begin
      if (m_phase == 1) begin
        if (st >= m_cfg.ts) begin
          if (m_first && st > m_cfg.ts) e_late = 1'b1;
          m_phase = 2; m_k = 0; do_load(0);
        end
        m_first = 1'b0;
      end else if (m_phase == 2) begin
        tp = 64'(m_cfg.tp);
        if ((m_k % tp == tp - 1) && (m_k / tp == 64'(m_cfg.n) - 1)) begin
          m_phase = 0; e_done = 1'b1;
        end else begin
          m_k++;
          if (m_k % tp == 0) do_load(m_k / tp);
        end
      end
    end
    if (m_phase == 2) begin
      t = m_k % 64'(m_cfg.tp);
      e_tx    = t < 64'(m_cfg.ti);
      e_blank = (t < 64'(m_cfg.tb1)) || (t + 64'(m_cfg.tb2) >= 64'(m_cfg.tp));
    end else begin
      e_tx = 1'b0; e_blank = 1'b0;
    end
  endtask

  task automatic check_all();
    chk("dds_freq",  64'(DDS_FREQ),  64'(e_freq));
    chk("dds_rate",  64'(DDS_RATE),  64'(e_rate));
    chk("dds_load",  64'(DDS_LOAD),  64'(e_load));
    chk("tx_gate",   64'(TX_GATE),   64'(e_tx));
    chk("blank",     64'(BLANK),     64'(e_blank));
    chk("pulse_cnt", 64'(PULSE_CNT), 64'(e_cnt));
    chk("busy",      64'(BUSY),      64'(m_phase != 0));
    chk("done",      64'(DONE),      64'(e_done));
    chk("err",       64'(ERR),       64'(e_err));
    chk("late",      64'(LATE),      64'(e_late));
  endtask

  task automatic step(input bit wr, input bit en, input bit r);
    rst = r; SPI_WR = wr; clk_en = en; SYS_TIME = st;
    FREQ = cur.freq; FREQ_STEP = cur.step; FREQ_RATE = cur.rate; TIME_START = cur.ts;
    N_impulse = cur.n; TYPE_impulse = cur.typ; Interval_Ti = cur.ti; Interval_Tp = cur.tp;
    Tblank1 = cur.tb1; Tblank2 = cur.tb2;
    @(posedge clk);
    model_edge(wr, en, r);
    if (!st_freeze) st = st + 64'd1;
    #1;
    check_all();
  endtask

  task automatic rand_cfg();
    cur = '0;
    cur.freq = 48'({$urandom(), $urandom()});
    cur.step = 48'({$urandom(), $urandom()});
    cur.rate = $urandom();
    cur.typ  = 8'($urandom());
    cur.n    = 16'($urandom_range(0, 4));
    cur.tp   = $urandom_range(1, 12);
    cur.ti   = $urandom_range(0, cur.tp);
    cur.tb1  = $urandom_range(0, 13);
    cur.tb2  = $urandom_range(0, 13);
    cur.ts   = st + 64'($urandom_range(0, 8)) - 64'($urandom_range(0, 3));
  endtask

  vec_t vecs[7];
  int   tx_n, ld_n, dn_n, last_ld, gap_bad, idx, run_ticks;
  logic [47:0] fq[3];
  logic [9:0]  bpat;
  bit          found;

  initial begin
    cur = '0; st = 64'd0; st_freeze = 1'b0;
    m_phase = 0; m_k = 0; m_first = 1'b0; m_cfg = '0;

    // Reset state
    step(0, 1, 1);
    step(1, 1, 1);
    chk("reset_busy", 64'(BUSY), 64'd0);
    chk("reset_freq", 64'(DDS_FREQ), 64'd0);

    // Validity table: (N, Ti, Tp) -> ERR expected
    vecs[0] = '{n: 16'd3, ti: 32'd4,  tp: 32'd10, exp_err: 1'b0};
    vecs[1] = '{n: 16'd3, ti: 32'd10, tp: 32'd10, exp_err: 1'b1};
    vecs[2] = '{n: 16'd0, ti: 32'd4,  tp: 32'd10, exp_err: 1'b1};
    vecs[3] = '{n: 16'd3, ti: 32'd0,  tp: 32'd10, exp_err: 1'b1};
    vecs[4] = '{n: 16'd3, ti: 32'd4,  tp: 32'd0,  exp_err: 1'b1};
    vecs[5] = '{n: 16'd1, ti: 32'd9,  tp: 32'd10, exp_err: 1'b0};
    vecs[6] = '{n: 16'd2, ti: 32'd11, tp: 32'd10, exp_err: 1'b1};
    for (int i = 0; i < 7; i++) begin
      cur = '0; cur.n = vecs[i].n; cur.ti = vecs[i].ti; cur.tp = vecs[i].tp;
      cur.ts = 64'hFFFF_FFFF_FFFF_FFFF;
      step(1, 1, 0);
      chk("tbl_err", 64'(ERR), 64'(vecs[i].exp_err));
      step(0, 1, 0);
      step(0, 1, 0);
      chk("tbl_busy", 64'(BUSY), 64'(!vecs[i].exp_err));
      chk("tbl_err_once", 64'(ERR), 64'd0);
    end

    // Basic train: Ti=4 Tp=10 N=3, start at 100 with time counting from 50
    cur = '0; cur.ti = 4; cur.tp = 10; cur.n = 3; cur.ts = 64'd100; st = 64'd50;
    step(1, 1, 0);
    tx_n = 0; ld_n = 0; dn_n = 0; last_ld = -1; gap_bad = 0;
    for (int c = 0; c < 150; c++) begin
      step(0, 1, 0);
      if (TX_GATE) tx_n++;
      if (DDS_LOAD) begin
        if (last_ld >= 0 && c - last_ld != 10) gap_bad++;
        last_ld = c; ld_n++;
      end
      if (DONE) dn_n++;
    end
    chk("basic_tx_cycles", 64'(tx_n), 64'd12);
    chk("basic_loads", 64'(ld_n), 64'd3);
    chk("basic_done", 64'(dn_n), 64'd1);
    chk("basic_load_gap", 64'(gap_bad), 64'd0);

    // Frequency hop wraps modulo 2^48
    cur = '0; cur.typ = 8'h01; cur.freq = 48'hFFFF_FFFF_FFFE; cur.step = 48'd3;
    cur.n = 3; cur.ti = 1; cur.tp = 2; cur.ts = st;
    step(1, 1, 0);
    idx = 0;
    for (int c = 0; c < 40; c++) begin
      step(0, 1, 0);
      if (DDS_LOAD && idx < 3) begin fq[idx] = DDS_FREQ; idx++; end
    end
    chk("hop_loads", 64'(idx), 64'd3);
    chk("hop_freq0", 64'(fq[0]), 64'h0000_FFFF_FFFF_FFFE);
    chk("hop_freq1", 64'(fq[1]), 64'd1);
    chk("hop_freq2", 64'(fq[2]), 64'd4);

    // Late start and blanking windows
    st_freeze = 1'b1; st = 64'd500;
    cur = '0; cur.ts = 64'd20; cur.ti = 4; cur.tp = 10; cur.n = 1; cur.tb1 = 2; cur.tb2 = 3;
    step(1, 1, 0);
    chk("late_armed_busy", 64'(BUSY), 64'd1);
    chk("late_not_yet", 64'(LATE), 64'd0);
    step(0, 1, 0);
    chk("late_set", 64'(LATE), 64'd1);
    chk("late_run_gate", 64'(TX_GATE), 64'd1);
    bpat = '0;
    bpat[0] = BLANK;
    for (int t = 1; t < 10; t++) begin
      step(0, 1, 0);
      bpat[t] = BLANK;
    end
    chk("blank_pattern", 64'(bpat), 64'(10'b11_1000_0011));
    step(0, 1, 0);
    st_freeze = 1'b0;

    // Abort mid-run with a new set
    cur = '0; cur.ti = 4; cur.tp = 10; cur.n = 5; cur.ts = st;
    step(1, 1, 0);
    found = 1'b0;
    for (int c = 0; c < 100; c++) begin
      step(0, 1, 0);
      if (PULSE_CNT == 16'd2 && TX_GATE) begin found = 1'b1; break; end
    end
    chk("abort_reach_pulse2", 64'(found), 64'd1);
    cur.n = 2; cur.ts = st + 64'd3;
    step(1, 1, 0);
    chk("abort_gate_low", 64'(TX_GATE), 64'd0);
    chk("abort_rearmed", 64'(BUSY), 64'd1);
    dn_n = 0; tx_n = 0;
    for (int c = 0; c < 100; c++) begin
      step(0, 1, 0);
      if (DONE) dn_n++;
      if (TX_GATE) tx_n++;
    end
    chk("abort_single_done", 64'(dn_n), 64'd1);
    chk("abort_new_tx", 64'(tx_n), 64'd8);

    // clk_en toggling doubles every duration
    cur = '0; cur.ti = 4; cur.tp = 10; cur.n = 3; cur.ts = st;
    step(1, 1, 0);
    tx_n = 0; ld_n = 0; last_ld = -1; gap_bad = 0;
    for (int c = 0; c < 200; c++) begin
      step(0, (c % 2) == 0, 0);
      if (TX_GATE) tx_n++;
      if (DDS_LOAD) begin
        if (last_ld >= 0 && c - last_ld != 20) gap_bad++;
        last_ld = c; ld_n++;
      end
    end
    chk("half_rate_tx", 64'(tx_n), 64'd24);
    chk("half_rate_loads", 64'(ld_n), 64'd3);
    chk("half_rate_gap", 64'(gap_bad), 64'd0);

    // Reset at t=3 inside a pulse
    cur.ts = st;
    step(1, 1, 0);
    step(0, 1, 0);
    chk("rst_seq_load", 64'(DDS_LOAD), 64'd1);
    step(0, 1, 0);
    step(0, 1, 0);
    step(0, 1, 0);
    chk("rst_seq_gate_before", 64'(TX_GATE), 64'd1);
    step(1, 1, 1);
    chk("rst_gate", 64'(TX_GATE), 64'd0);
    chk("rst_blank", 64'(BLANK), 64'd0);
    chk("rst_busy", 64'(BUSY), 64'd0);
    chk("rst_cnt", 64'(PULSE_CNT), 64'd0);

    // Randomized traffic against the model
    for (int it = 0; it < 30; it++) begin
      rand_cfg();
      step(1, 1, 0);
      run_ticks = 0;
      while (run_ticks < 300 && m_phase != 0) begin
        if ($urandom_range(0, 79) == 0) begin
          rand_cfg();
          step(1, $urandom_range(0, 3) != 0, 0);
        end else begin
          step(0, $urandom_range(0, 3) != 0, $urandom_range(0, 249) == 0);
        end
        run_ticks++;
      end
      step(0, 1, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
